// File: rtl/ws2812_rx_sfr.sv
// WS2812 one-wire receiver: decodes 24-bit GRB pixels and exposes them on the 8051 SFR bus.
// Define WS_RX_GLITCH_FILTER_EN to reject din pulses of 2 cycles or less.
module ws2812_rx_sfr #(
  parameter int unsigned HIGH_THRESH  = 30,
  parameter int unsigned MAX_HIGH     = 60,
  parameter int unsigned RESET_CYCLES = 2500,
  parameter logic [7:0]  ADDR_G       = 8'hc8,
  parameter logic [7:0]  ADDR_R       = 8'hc9,
  parameter logic [7:0]  ADDR_B       = 8'hca,
  parameter logic [7:0]  ADDR_STAT    = 8'hcb
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] controller_data_in,
  input  logic       sfr_wr,
  input  logic       sfr_rd,
  output logic [7:0] controller_data_out,
  output logic [7:0] pixel_idx
);

  localparam logic [11:0] ResetCnt = 12'(RESET_CYCLES);
  localparam logic [6:0]  HighThr  = 7'(HIGH_THRESH);
  localparam logic [6:0]  MaxHigh  = 7'(MAX_HIGH);

  typedef enum logic [1:0] {StSync, StLow, StHigh} state_e;

  state_e      state_q, state_d;
  logic        din_s1_q, din_s2_q, ds;
  logic [11:0] lcnt_q, lcnt_d, lcnt_inc;
  logic [6:0]  hcnt_q, hcnt_d, hcnt_inc;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  g_q, r_q, b_q, pixel_idx_q, rdata;
  logic        valid_q, ovr_q, fdone_q, err_q;
  logic        latch, frame_end, err_set, rd_b, rd_stat, clr_wr;
  logic        unused_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_s1_q <= 1'b0;
      din_s2_q <= 1'b0;
    end else begin
      din_s1_q <= din;
      din_s2_q <= din_s1_q;
    end
  end

`ifdef WS_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       ds_q;

  // ds follows the synchroniser only once three consecutive samples agree.
  always_comb begin
    ds = ds_q;
    if ((din_s2_q == hist_q[0]) && (din_s2_q == hist_q[1])) ds = din_s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b00;
      ds_q   <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], din_s2_q};
      ds_q   <= ds;
    end
  end
`else
  assign ds = din_s2_q;
`endif

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    hcnt_d    = hcnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    pcnt_d    = pcnt_q;
    latch     = 1'b0;
    frame_end = 1'b0;
    err_set   = 1'b0;
    lcnt_inc  = (lcnt_q == 12'hfff) ? lcnt_q : lcnt_q + 12'd1;
    hcnt_inc  = (hcnt_q == 7'h7f) ? hcnt_q : hcnt_q + 7'd1;

    // bitcnt reaches 24 on a falling edge; the pixel is taken on the following cycle.
    if (bitcnt_q == 5'd24) begin
      latch    = 1'b1;
      bitcnt_d = 5'd0;
      pcnt_d   = (pcnt_q == 8'hff) ? pcnt_q : pcnt_q + 8'd1;
    end

    case (state_q)
      StSync: begin
        if (ds) begin
          lcnt_d = 12'd0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == ResetCnt) begin
            state_d = StLow;
            pcnt_d  = 8'd0;
          end
        end
      end
      StLow: begin
        if (ds) begin
          state_d = StHigh;
          hcnt_d  = 7'd0;
          lcnt_d  = 12'd0;
        end else begin
          lcnt_d = lcnt_inc;
          if ((lcnt_q != ResetCnt) && (lcnt_inc == ResetCnt)) begin
            frame_end = 1'b1;
            bitcnt_d  = 5'd0;
            pcnt_d    = 8'd0;
          end
        end
      end
      StHigh: begin
        if (!ds) begin
          shift_d  = {shift_q[22:0], (hcnt_q > HighThr)};
          bitcnt_d = bitcnt_q + 5'd1;
          lcnt_d   = 12'd0;
          state_d  = StLow;
        end else begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == MaxHigh) begin
            err_set  = 1'b1;
            bitcnt_d = 5'd0;
            lcnt_d   = 12'd0;
            state_d  = StSync;
          end
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StSync;
      lcnt_q   <= 12'd0;
      hcnt_q   <= 7'd0;
      bitcnt_q <= 5'd0;
      shift_q  <= 24'd0;
      pcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      hcnt_q   <= hcnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign rd_b         = sfr_rd && (sfr_addr == ADDR_B);
  assign rd_stat      = sfr_rd && (sfr_addr == ADDR_STAT);
  assign clr_wr       = sfr_wr && (sfr_addr == ADDR_STAT) && controller_data_in[7];
  assign unused_wdata = ^controller_data_in[6:0];

  always_comb begin
    rdata = 8'h00;
    case (sfr_addr)
      ADDR_G:    rdata = g_q;
      ADDR_R:    rdata = r_q;
      ADDR_B:    rdata = b_q;
      ADDR_STAT: rdata = {4'h0, err_q, fdone_q, ovr_q, valid_q};
      default:   rdata = 8'h00;
    endcase
  end

  // Set events take priority over bus-driven clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q                 <= 8'h00;
      r_q                 <= 8'h00;
      b_q                 <= 8'h00;
      valid_q             <= 1'b0;
      ovr_q               <= 1'b0;
      fdone_q             <= 1'b0;
      err_q               <= 1'b0;
      pixel_idx_q         <= 8'h00;
      controller_data_out <= 8'h00;
    end else begin
      if (latch) {g_q, r_q, b_q} <= shift_q;
      valid_q <= latch | (valid_q & ~rd_b);
      ovr_q   <= (latch & valid_q) | (ovr_q & ~clr_wr);
      fdone_q <= (frame_end & (pcnt_q != 8'd0)) | (fdone_q & ~rd_stat);
      err_q   <= err_set | (err_q & ~clr_wr);
      if (latch) begin
        pixel_idx_q <= pcnt_q;
      end else if (clr_wr) begin
        pixel_idx_q <= 8'h00;
      end
      controller_data_out <= rdata;
    end
  end

  assign pixel_idx = pixel_idx_q;

endmodule
